bank_controller: RTL and testbench

Per-bank command sequencer that sits between the channel-level command decoder and one Bank datapath instance. It accepts ACT/RD/WR/PRE commands through a valid/ready handshake and enforces tRCD, tCL and tRP with down-counters. It drives the Bank's rd_o_wr/row/column/dqin for BL-beat bursts and returns read data with a valid strobe. Illegal commands for the current bank state are rejected with an error pulse.

---
 rtl/bank_ctrl_pkg.sv | 31 +++
 rtl/bank_controller_timing_counter.sv | 31 +++
 rtl/bank_controller.sv | 174 +++++++++++++++++
 tb/tb_bank_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_ctrl_pkg.sv
// Shared types for the per-bank command sequencer: command opcodes, FSM states
// and the sizing helper for the shared timing counter.
package bank_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ACT = 2'd0,
    OP_RD  = 2'd1,
    OP_WR  = 2'd2,
    OP_PRE = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ACTIVATING  = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_READ_WAIT   = 3'd3,
    ST_READING     = 3'd4,
    ST_WRITING     = 3'd5,
    ST_PRECHARGING = 3'd6
  } state_e;

  // The counter only ever holds t-1 for the largest of the three delays.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/bank_controller_timing_counter.sv
// Loadable down-counter shared by the tRCD/tCL/tRP waits.
module timing_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_r;

  // Load on command accept, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // High on the final wait cycle, i.e. as the count steps to zero, so a wait
  // state loaded with t-1 lasts t-1 cycles and the next command lands t after.
  assign zero = (cnt_r <= WIDTH'(1));

endmodule

// File: rtl/bank_controller.sv
// Per-bank command sequencer: ACT/RD/WR/PRE handshake, tRCD/tCL/tRP timing,
// BL-beat bursts to the Bank datapath and read data return.
module bank_controller
  import bank_ctrl_pkg::*;
#(
  parameter int DEVICE_WIDTH = 4,
  parameter int ROWS         = 131072,
  parameter int COLS         = 1024,
  parameter int BL           = 8,
  parameter int tRCD         = 14,
  parameter int tCL          = 14,
  parameter int tRP          = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(ROWS)-1:0]  cmd_row,
  input  logic [$clog2(COLS)-1:0]  cmd_col,
  input  logic [DEVICE_WIDTH-1:0]  wdata,
  output logic [DEVICE_WIDTH-1:0]  rdata,
  output logic                     rdata_valid,
  output logic                     cmd_err,
  output logic                     open_row,
  output logic                     bank_rd_o_wr,
  output logic [$clog2(ROWS)-1:0]  bank_row,
  output logic [$clog2(COLS)-1:0]  bank_column,
  output logic [DEVICE_WIDTH-1:0]  bank_dqin,
  input  logic [DEVICE_WIDTH-1:0]  bank_dqout
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int BEAT_W = $clog2(BL) + 1;
  localparam int CNT_W  = cnt_width(tRCD, tCL, tRP);
  localparam logic [CNT_W-1:0]  RCD_LD    = CNT_W'(tRCD - 1);
  localparam logic [CNT_W-1:0]  CL_LD     = CNT_W'(tCL - 1);
  localparam logic [CNT_W-1:0]  RP_LD     = CNT_W'(tRP - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BL - 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);

  state_e             state_r, next_s;
  cmd_op_e            op_s;
  logic               accept_s, cnt_load_s, cnt_zero_s, err_s, burst_s;
  logic [CNT_W-1:0]   cnt_val_s;
  logic [BEAT_W-1:0]  beat_r;
  logic [COL_W-1:0]   col_r, bank_column_r, col_inc_s;
  logic [ROW_W-1:0]   bank_row_r;
  logic               cmd_ready_r, open_row_r, cmd_err_r, rdata_valid_r, bank_rd_o_wr_r;

  assign op_s      = cmd_op_e'(cmd_op);
  assign accept_s  = cmd_valid && cmd_ready_r;
  assign burst_s   = (state_r == ST_READING) || (state_r == ST_WRITING);
  assign col_inc_s = (bank_column_r == COL_MAX) ? {COL_W{1'b0}} : bank_column_r + COL_W'(1);

  timing_counter #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // Next-state, timer load and illegal-command detection.
  always_comb begin
    next_s     = state_r;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_ACT: begin
              cnt_load_s = 1'b1;
              cnt_val_s  = RCD_LD;
              next_s     = (tRCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
            end
            OP_RD, OP_WR: err_s = 1'b1;
            default: next_s = ST_IDLE;
          endcase
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ACTIVATING:  next_s = cnt_zero_s ? ST_ACTIVE : ST_ACTIVATING;
      ST_ACTIVE: begin
        if (accept_s) begin
          case (op_s)
            OP_RD: begin
              cnt_load_s = 1'b1;
              cnt_val_s  = CL_LD;
              next_s     = (tCL == 1) ? ST_READING : ST_READ_WAIT;
            end
            OP_WR: next_s = ST_WRITING;
            OP_PRE: begin
              cnt_load_s = 1'b1;
              cnt_val_s  = RP_LD;
              next_s     = (tRP == 1) ? ST_IDLE : ST_PRECHARGING;
            end
            default: err_s = 1'b1;
          endcase
        end else begin
          next_s = ST_ACTIVE;
        end
      end
      ST_READ_WAIT:   next_s = cnt_zero_s ? ST_READING : ST_READ_WAIT;
      ST_READING:     next_s = (beat_r == LAST_BEAT) ? ST_ACTIVE : ST_READING;
      ST_WRITING:     next_s = (beat_r == LAST_BEAT) ? ST_ACTIVE : ST_WRITING;
      ST_PRECHARGING: next_s = cnt_zero_s ? ST_IDLE : ST_PRECHARGING;
      default:        next_s = ST_IDLE;
    endcase
  end

  // Registered handshake/status outputs and burst address generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r    <= 1'b1;
      open_row_r     <= 1'b0;
      cmd_err_r      <= 1'b0;
      rdata_valid_r  <= 1'b0;
      bank_rd_o_wr_r <= 1'b0;
      bank_row_r     <= {ROW_W{1'b0}};
      bank_column_r  <= {COL_W{1'b0}};
      col_r          <= {COL_W{1'b0}};
      beat_r         <= {BEAT_W{1'b0}};
    end else begin
      cmd_ready_r    <= (next_s == ST_IDLE) || (next_s == ST_ACTIVE);
      open_row_r     <= (next_s == ST_ACTIVE) || (next_s == ST_READ_WAIT) ||
                        (next_s == ST_READING) || (next_s == ST_WRITING);
      cmd_err_r      <= err_s;
      rdata_valid_r  <= (state_r == ST_READING);
      bank_rd_o_wr_r <= (next_s == ST_WRITING);
      if (state_r == ST_IDLE && accept_s && op_s == OP_ACT) begin
        bank_row_r <= cmd_row;
      end
      if (state_r == ST_ACTIVE && accept_s) begin
        col_r <= cmd_col;
      end
      // Burst entry takes the column straight from the command when there is
      // no read wait in between.
      if (!burst_s && (next_s == ST_READING || next_s == ST_WRITING)) begin
        beat_r        <= {BEAT_W{1'b0}};
        bank_column_r <= (state_r == ST_ACTIVE) ? cmd_col : col_r;
      end else if (burst_s && next_s == state_r) begin
        beat_r        <= beat_r + BEAT_W'(1);
        bank_column_r <= col_inc_s;
      end else begin
        beat_r        <= beat_r;
        bank_column_r <= bank_column_r;
      end
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign open_row     = open_row_r;
  assign cmd_err      = cmd_err_r;
  assign rdata_valid  = rdata_valid_r;
  assign bank_rd_o_wr = bank_rd_o_wr_r;
  assign bank_row     = bank_row_r;
  assign bank_column  = bank_column_r;
  // The Bank returns data one cycle after the address, aligned with the
  // registered strobe; both data paths are gated so reset silences them at once.
  assign rdata        = rdata_valid_r ? bank_dqout : {DEVICE_WIDTH{1'b0}};
  assign bank_dqin    = bank_rd_o_wr_r ? wdata : {DEVICE_WIDTH{1'b0}};

endmodule

// File: tb/tb_bank_controller.sv
// Self-checking bench for bank_controller with a behavioural Bank model and a
// read-data scoreboard.
module tb_bank_controller;
  import bank_ctrl_pkg::*;

  localparam int TRCD = 14;
  localparam int TCL  = 14;
  localparam int TRP  = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [16:0] cmd_row = '0;
  logic [9:0]  cmd_col = '0;
  logic [3:0]  wdata = '0;
  logic [3:0]  rdata;
  logic        rdata_valid, cmd_err, open_row, bank_rd_o_wr;
  logic [16:0] bank_row;
  logic [9:0]  bank_column;
  logic [3:0]  bank_dqin;
  logic [3:0]  bank_dqout = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mem [logic [26:0]];

  bank_controller dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .cmd_err(cmd_err),
    .open_row(open_row), .bank_rd_o_wr(bank_rd_o_wr), .bank_row(bank_row),
    .bank_column(bank_column), .bank_dqin(bank_dqin), .bank_dqout(bank_dqout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: synchronous SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bank_rd_o_wr) begin
      mem[{bank_row, bank_column}] = bank_dqin;
      wr_count = wr_count + 1;
    end
    bank_dqout <= mem.exists({bank_row, bank_column}) ? mem[{bank_row, bank_column}] : 4'h0;
  end

  // Scoreboard: every valid read beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rdata_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rdata_unexpected: rdata=%h with no beat expected", rdata);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("FAIL rdata: got %h expected %h", rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [16:0] row,
                      input logic [9:0] col, output int acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL send_ready: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_col = col;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rdata_valid) && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d read beats never returned, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if (cmd_ready !== 1'b1 || {rdata_valid, cmd_err, open_row, bank_rd_o_wr} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b open=%b wr=%b, expected 1 0 0 0 0",
               cmd_ready, rdata_valid, cmd_err, open_row, bank_rd_o_wr);
    end
    tests++;
    if ({rdata, bank_row, bank_column, bank_dqin} !== 35'd0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h row=%h col=%h dqin=%h, expected all 0",
               rdata, bank_row, bank_column, bank_dqin);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_act_rd();
    int a, r, first, n, last;
    send(OP_ACT, 17'd5, 10'd0, a);
    tests++;
    if (open_row !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL activating: open_row=%b cmd_ready=%b, expected 0 0", open_row, cmd_ready);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(4'h0);
    send(OP_RD, 17'd0, 10'd0, r);
    tests++;
    if (r - a !== TRCD) begin
      fails++;
      $display("FAIL trcd_gap: RD accepted %0d cycles after ACT, expected %0d", r - a, TRCD);
    end
    first = -1; n = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      if (rdata_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      step();
    end
    tests++;
    if (first !== r + TCL + 1) begin
      fails++;
      $display("FAIL tcl_first_valid: first valid at +%0d, expected +%0d", first - r, TCL + 1);
    end
    tests++;
    if (n !== 8 || last - first + 1 !== 8) begin
      fails++;
      $display("FAIL read_strobe: %0d valid beats over %0d cycles, expected 8 over 8", n, last - first + 1);
    end
    drain();
  endtask

  task automatic test_wr_rd();
    int w, r, wc0;
    wc0 = wr_count;
    send(OP_WR, 17'd0, 10'd16, w);
    for (int i = 0; i < 8; i++) begin
      wdata = 4'(i);
      tests++;
      if (bank_rd_o_wr !== 1'b1 || bank_column !== 10'(16 + i)) begin
        fails++;
        $display("FAIL wr_beat%0d: wr=%b col=%0d, expected 1 %0d", i, bank_rd_o_wr, bank_column, 16 + i);
      end
      step();
    end
    wdata = 4'h0;
    tests++;
    if (bank_rd_o_wr !== 1'b0 || wr_count - wc0 !== 8) begin
      fails++;
      $display("FAIL wr_count: wr=%b writes=%0d, expected 0 8", bank_rd_o_wr, wr_count - wc0);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
    send(OP_RD, 17'd0, 10'd16, r);
    drain();
  endtask

  task automatic test_wrap_back_to_back();
    int w, r;
    logic [3:0] d;
    send(OP_WR, 17'd0, 10'd1020, w);
    for (int i = 0; i < 8; i++) begin
      d = 4'(i * 3 + 1);
      wdata = d;
      exp_q.push_back(d);
      tests++;
      if (bank_column !== 10'((1020 + i) % 1024)) begin
        fails++;
        $display("FAIL wrap_col%0d: col=%0d, expected %0d", i, bank_column, (1020 + i) % 1024);
      end
      step();
    end
    wdata = 4'h0;
    send(OP_RD, 17'd0, 10'd1020, r);
    tests++;
    if (r !== w + 9) begin
      fails++;
      $display("FAIL back_to_back: RD accepted %0d cycles after WR, expected 9", r - w);
    end
    drain();
  endtask

  task automatic test_err_active();
    int e, wc0;
    wc0 = wr_count;
    send(OP_ACT, 17'd9, 10'd0, e);
    tests++;
    if (cmd_err !== 1'b1 || open_row !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_act: err=%b open=%b ready=%b, expected 1 1 1", cmd_err, open_row, cmd_ready);
    end
    step();
    tests++;
    if (cmd_err !== 1'b0 || bank_row !== 17'd5 || wr_count !== wc0) begin
      fails++;
      $display("FAIL err_act_after: err=%b row=%0d writes=%0d, expected 0 5 0", cmd_err, bank_row, wr_count - wc0);
    end
  endtask

  task automatic test_precharge();
    int p, n;
    send(OP_PRE, 17'd0, 10'd0, p);
    tests++;
    if (open_row !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL pre_start: open=%b ready=%b, expected 0 0", open_row, cmd_ready);
    end
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (cyc !== p + TRP || open_row !== 1'b0) begin
      fails++;
      $display("FAIL trp: idle %0d cycles after PRE open=%b, expected %0d 0", cyc - p, open_row, TRP);
    end
  endtask

  task automatic test_err_idle();
    int e, wc0, nv;
    wc0 = wr_count;
    send(OP_RD, 17'd0, 10'd0, e);
    tests++;
    if (cmd_err !== 1'b1 || open_row !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_rd_idle: err=%b open=%b ready=%b, expected 1 0 1", cmd_err, open_row, cmd_ready);
    end
    nv = 0;
    step();
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: err=%b, expected 0", cmd_err);
    end
    for (int i = 0; i < 20; i++) begin
      if (rdata_valid || bank_rd_o_wr) nv++;
      step();
    end
    tests++;
    if (nv !== 0 || wr_count !== wc0) begin
      fails++;
      $display("FAIL err_no_access: accesses=%0d writes=%0d, expected 0 0", nv, wr_count - wc0);
    end
    send(OP_PRE, 17'd0, 10'd0, e);
    tests++;
    if (cmd_err !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL pre_idle: err=%b ready=%b, expected 0 1", cmd_err, cmd_ready);
    end
  endtask

  task automatic test_reset_midburst();
    int a, w, wc0, wc1;
    send(OP_ACT, 17'd3, 10'd0, a);
    wc0 = wr_count;
    send(OP_WR, 17'd0, 10'd50, w);
    for (int i = 0; i < 3; i++) begin
      wdata = 4'(i + 8);
      step();
    end
    wdata = 4'hB;
    rst = 1'b1;
    #1;
    tests++;
    if ({rdata_valid, cmd_err, open_row, bank_rd_o_wr} !== 4'b0 ||
        {rdata, bank_row, bank_column, bank_dqin} !== 35'd0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_midburst: wr=%b open=%b dqin=%h row=%h col=%h ready=%b, expected 0 0 0 0 0 1",
               bank_rd_o_wr, open_row, bank_dqin, bank_row, bank_column, cmd_ready);
    end
    wc1 = wr_count;
    repeat (3) step();
    rst = 1'b0;
    step();
    tests++;
    if (bank_rd_o_wr !== 1'b0 || cmd_ready !== 1'b1 || wr_count !== wc1 || wc1 - wc0 !== 3) begin
      fails++;
      $display("FAIL rst_release: wr=%b ready=%b burst writes=%0d later writes=%0d, expected 0 1 3 0",
               bank_rd_o_wr, cmd_ready, wc1 - wc0, wr_count - wc1);
    end
  endtask

  initial begin
    test_reset();
    test_act_rd();
    test_wr_rd();
    test_wrap_back_to_back();
    test_err_active();
    test_precharge();
    test_err_idle();
    test_reset_midburst();
    repeat (4) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d beats outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
